tero_response_accumulator: RTL and testbench

- Downstream stage of the TERO evaluation controller.
- Counts oscillator rising edges of the selected TERO loop during each enable_puf window, accumulates them over all repetitions, and stores one average per loop when store_response_puf pulses.
- After the last loop is stored, compares loop pairs to produce the PUF response bits.
- Drives next_enable back to the controller.

---
 rtl/tero_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/tero_response_accumulator.sv | 166 ++++++++++++++++
 tb/tb_tero_response_accumulator.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tero_pkg.sv
// Shared types and width helpers for the TERO PUF response path.
package tero_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPARE = 2'd1,
    VALID   = 2'd2
  } state_t;

  localparam int DEF_CNT_BITS = 16;
  localparam int DEF_REP_BITS = 13;

  // Averaging over 2**(rep_bits-1) repetitions is a plain right shift.
  function automatic int avg_shift(input int rep_bits);
    return rep_bits - 1;
  endfunction

  // Wide enough to sum every window of a loop without overflow.
  function automatic int acc_bits(input int cnt_bits, input int rep_bits);
    return cnt_bits + rep_bits;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for signals crossing into clk; resets to zero.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tero_response_accumulator.sv
// Counts TERO oscillations per window, averages them per loop and compares
// loop pairs into PUF response bits.
//
//   state   | meaning
//   COLLECT | accepting windows and stores, response not valid
//   COMPARE | one loop pair compared per cycle, stores rejected
//   VALID   | response valid, still accepting windows and stores
module tero_response_accumulator
  import tero_pkg::*;
#(
  parameter int NUM_LOOPS        = 4,
  parameter int REPETITIONS_BITS = DEF_REP_BITS,
  parameter int CNT_BITS         = DEF_CNT_BITS,
  parameter int SEL_BITS         = $clog2(NUM_LOOPS-1) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tero_osc,
  input  logic                   reset_puf,
  input  logic                   enable_puf,
  input  logic [SEL_BITS-1:0]    select_puf,
  input  logic                   store_response_puf,
  output logic                   next_enable,
  output logic [NUM_LOOPS/2-1:0] response,
  output logic                   response_valid,
  output logic                   overrun,
  input  logic [SEL_BITS-1:0]    rd_addr,
  output logic [CNT_BITS-1:0]    rd_data
);

  localparam int ACC_BITS = acc_bits(CNT_BITS, REPETITIONS_BITS);
  localparam int SHIFT    = avg_shift(REPETITIONS_BITS);
  localparam int PAIRS    = NUM_LOOPS / 2;
  localparam int K_BITS   = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  logic                sync_q;
  logic                sync_q_d1;
  logic                osc_edge;
  logic                enable_d1;
  logic                win_close;
  logic                win_open;
  logic [CNT_BITS-1:0] win_cnt;
  logic [ACC_BITS-1:0] acc;
  logic [ACC_BITS-1:0] sum;
  logic [CNT_BITS-1:0] avg [NUM_LOOPS];
  state_t              state;
  logic [K_BITS-1:0]   k;
  logic                store_ok;
  logic                store_last;
  logic                cmp_bit;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (tero_osc),
    .q     (sync_q)
  );

  assign osc_edge   = sync_q & ~sync_q_d1;
  assign win_close  = enable_d1 & ~enable_puf;
  assign win_open   = enable_puf & ~enable_d1;
  // The last window of a loop closes in the same cycle as its store.
  assign sum        = acc + (win_close ? ACC_BITS'(win_cnt) : '0);
  assign store_ok   = store_response_puf && (state != COMPARE);
  assign store_last = store_ok && (select_puf == SEL_BITS'(NUM_LOOPS-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q_d1 <= 1'b0;
      enable_d1 <= 1'b0;
    end else begin
      sync_q_d1 <= sync_q;
      enable_d1 <= enable_puf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || reset_puf || win_close) begin
      win_cnt <= '0;
    end else if (enable_puf && osc_edge && (win_cnt != '1)) begin
      win_cnt <= win_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (store_ok) begin
      acc <= '0;
    end else if (win_close) begin
      acc <= sum;
    end
  end

  // Out-of-range selects match no slot, so the average is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LOOPS; i++) avg[i] <= '0;
    end else if (store_ok) begin
      for (int i = 0; i < NUM_LOOPS; i++) begin
        if (select_puf == SEL_BITS'(i)) avg[i] <= sum[SHIFT +: CNT_BITS];
      end
    end
  end

  always_comb begin
    cmp_bit = 1'b0;
    for (int i = 0; i < PAIRS; i++) begin
      if (k == K_BITS'(i)) cmp_bit = (avg[2*i] > avg[2*i+1]);
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_LOOPS; i++) begin
      if (rd_addr == SEL_BITS'(i)) rd_data = avg[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= COLLECT;
      k              <= '0;
      response       <= '0;
      response_valid <= 1'b0;
      next_enable    <= 1'b1;
      overrun        <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (store_last) begin
            state       <= COMPARE;
            k           <= '0;
            next_enable <= 1'b0;
          end
        end
        COMPARE: begin
          if (store_response_puf) overrun <= 1'b1;
          for (int i = 0; i < PAIRS; i++) begin
            if (k == K_BITS'(i)) response[i] <= cmp_bit;
          end
          if (k == K_BITS'(PAIRS-1)) begin
            state          <= VALID;
            response_valid <= 1'b1;
            next_enable    <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
        VALID: begin
          if (store_last) begin
            state          <= COMPARE;
            k              <= '0;
            next_enable    <= 1'b0;
            response_valid <= 1'b0;
          end else if (win_open) begin
            state          <= COLLECT;
            response_valid <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_tero_response_accumulator.sv
// Directed bench for tero_response_accumulator: expected responses go through a
// scoreboard queue consumed by a monitor on each rising response_valid.
module tb_tero_response_accumulator;

  localparam int NL = 4;
  localparam int RB = 3;
  localparam int CB = 8;
  localparam int SB = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          tero_osc;
  logic          reset_puf;
  logic          enable_puf;
  logic [SB-1:0] select_puf;
  logic          store_response_puf;
  logic          next_enable;
  logic [1:0]    response;
  logic          response_valid;
  logic          overrun;
  logic [SB-1:0] rd_addr;
  logic [CB-1:0] rd_data;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [1:0] exp_q[$];
  logic [1:0] mon_exp;
  logic       rv_prev = 1'b0;

  always #5 clk = ~clk;

  tero_response_accumulator #(
    .NUM_LOOPS        (NL),
    .REPETITIONS_BITS (RB),
    .CNT_BITS         (CB),
    .SEL_BITS         (SB)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .tero_osc           (tero_osc),
    .reset_puf          (reset_puf),
    .enable_puf         (enable_puf),
    .select_puf         (select_puf),
    .store_response_puf (store_response_puf),
    .next_enable        (next_enable),
    .response           (response),
    .response_valid     (response_valid),
    .overrun            (overrun),
    .rd_addr            (rd_addr),
    .rd_data            (rd_data)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: every rising response_valid consumes one expected response.
  always @(negedge clk) begin
    if (response_valid === 1'b1 && rv_prev == 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected response_valid: got response %0d, expected none", response);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("response", int'(response), int'(mon_exp));
      end
    end
    rv_prev <= response_valid;
  end

  task automatic pulses(input int n);
    repeat (n) begin
      tero_osc = 1'b1;
      @(negedge clk);
      tero_osc = 1'b0;
      @(negedge clk);
    end
  endtask

  // One evaluation window; optionally the store pulse on the closing cycle.
  task automatic window(input int n, input bit st, input int sel, input bit inject);
    enable_puf = 1'b1;
    @(negedge clk);
    pulses(n);
    repeat (4) @(negedge clk);
    enable_puf         = 1'b0;
    store_response_puf = st;
    select_puf         = sel[SB-1:0];
    @(negedge clk);
    store_response_puf = 1'b0;
    if (st && sel == NL-1) begin
      chk("next_enable T+1", int'(next_enable), 0);
      chk("response_valid T+1", int'(response_valid), 0);
      if (inject) begin
        store_response_puf = 1'b1;
        select_puf         = 3'd1;
      end
      @(negedge clk);
      store_response_puf = 1'b0;
      chk("next_enable T+2", int'(next_enable), 0);
      chk("response_valid T+2", int'(response_valid), 0);
      @(negedge clk);
      chk("next_enable T+3", int'(next_enable), 1);
      chk("response_valid T+3", int'(response_valid), 1);
    end
    @(negedge clk);
  endtask

  task automatic loop4(input int a, input int b, input int c, input int d,
                       input int sel, input bit inject);
    window(a, 1'b0, sel, 1'b0);
    window(b, 1'b0, sel, 1'b0);
    window(c, 1'b0, sel, 1'b0);
    window(d, 1'b1, sel, inject);
  endtask

  task automatic run(input int v0, input int v1, input int v2, input int v3,
                     input logic [1:0] exp, input bit inject);
    exp_q.push_back(exp);
    loop4(v0, v0, v0, v0, 0, 1'b0);
    loop4(v1, v1, v1, v1, 1, 1'b0);
    loop4(v2, v2, v2, v2, 2, 1'b0);
    loop4(v3, v3, v3, v3, 3, inject);
  endtask

  task automatic check_avgs(input int a0, input int a1, input int a2, input int a3);
    int e[4];
    e[0] = a0; e[1] = a1; e[2] = a2; e[3] = a3;
    for (int i = 0; i < NL; i++) begin
      rd_addr = SB'(i);
      #1;
      chk($sformatf("rd_data[%0d]", i), int'(rd_data), e[i]);
    end
  endtask

  task automatic check_reset_state();
    chk("reset next_enable", int'(next_enable), 1);
    chk("reset response_valid", int'(response_valid), 0);
    chk("reset response", int'(response), 0);
    chk("reset overrun", int'(overrun), 0);
    check_avgs(0, 0, 0, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    reset              = 1'b1;
    tero_osc           = 1'b0;
    reset_puf          = 1'b0;
    enable_puf         = 1'b0;
    store_response_puf = 1'b0;
    select_puf         = '0;
    rd_addr            = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_state();
    @(negedge clk);

    // Unequal windows on loop 0: (10+12+14+16)/4 = 13.
    loop4(10, 12, 14, 16, 0, 1'b0);
    rd_addr = 3'd0;
    #1;
    chk("avg loop0 single", int'(rd_data), 13);

    // Loop 0 restored to 20 only if acc was cleared by the previous store.
    run(20, 15, 7, 9, 2'b01, 1'b0);
    check_avgs(20, 15, 7, 9);

    run(9, 9, 30, 2, 2'b10, 1'b0);
    check_avgs(9, 9, 30, 2);

    run(300, 5, 3, 4, 2'b01, 1'b0);
    check_avgs(255, 5, 3, 4);

    // Reset in the middle of loop 2's first window.
    loop4(6, 6, 6, 6, 0, 1'b0);
    loop4(2, 2, 2, 2, 1, 1'b0);
    enable_puf = 1'b1;
    @(negedge clk);
    pulses(5);
    reset      = 1'b1;
    enable_puf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state();
    @(negedge clk);

    run(8, 3, 12, 11, 2'b11, 1'b0);
    chk("overrun after clean run", int'(overrun), 0);
    check_avgs(8, 3, 12, 11);

    // Out-of-range select: averages untouched, acc still cleared.
    loop4(50, 50, 50, 50, 4, 1'b0);
    check_avgs(8, 3, 12, 11);
    rd_addr = 3'd4;
    #1;
    chk("rd_data out of range", int'(rd_data), 0);

    // Store injected during COMPARE must be ignored and flagged.
    run(4, 6, 6, 1, 2'b10, 1'b1);
    chk("overrun after injection", int'(overrun), 1);
    check_avgs(4, 6, 6, 1);

    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard drain: got %0d pending, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
